// File: rtl/runway_pkg.sv
// Shared runway definitions: state encoding, default timing and counter sizing.
package runway_pkg;

    typedef enum logic [1:0] {
        RWY_FREE     = 2'b00,
        RWY_OCCUPIED = 2'b01,
        RWY_CLEARING = 2'b10,
        RWY_CLOSED   = 2'b11
    } rwy_state_t;

    localparam int OCC_CYCLES_DEF   = 12;
    localparam int CLEAR_CYCLES_DEF = 3;

    // Width that holds the longer of the two dwell times without wrapping.
    function automatic int cnt_width(input int occ, input int clr);
        int m;
        m = (occ > clr) ? occ : clr;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/runway_slot.sv
// One runway: occupancy/clearance sequencer with a dwell counter and close handling.
//
//   state    | meaning
//   FREE     | idle, may be granted or closed
//   OCCUPIED | aircraft on runway for OCC_CYCLES cycles
//   CLEARING | post-occupancy clearance for CLEAR_CYCLES cycles
//   CLOSED   | held out of service while close is high
module runway_slot
    import runway_pkg::*;
#(
    parameter int OCC_CYCLES   = OCC_CYCLES_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_grant,
    input  logic       i_close,
    output logic [1:0] o_state
);

    localparam int CNT_W = cnt_width(OCC_CYCLES, CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] OCC_LAST = CNT_W'(OCC_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    rwy_state_t       r_state;
    rwy_state_t       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RWY_FREE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RWY_FREE: begin
                // Close wins over a same-edge grant; the arbiter never targets a closing runway.
                if (i_close)
                    w_next_state = RWY_CLOSED;
                else if (i_grant)
                    w_next_state = RWY_OCCUPIED;
            end
            RWY_OCCUPIED: begin
                if (r_cnt == OCC_LAST)
                    w_next_state = RWY_CLEARING;
            end
            RWY_CLEARING: begin
                if (r_cnt == CLR_LAST)
                    w_next_state = i_close ? RWY_CLOSED : RWY_FREE;
            end
            RWY_CLOSED: begin
                if (!i_close)
                    w_next_state = RWY_FREE;
            end
            default: w_next_state = RWY_FREE;
        endcase
    end

    // Counter restarts on every state entry and saturates rather than wrapping.
    always_comb begin
        w_next_cnt = r_cnt;
        if (w_next_state != r_state)
            w_next_cnt = '0;
        else if (((r_state == RWY_OCCUPIED) || (r_state == RWY_CLEARING)) && (r_cnt != '1))
            w_next_cnt = r_cnt + CNT_W'(1);
    end

    assign o_state = r_state;

endmodule

// File: rtl/runway_scheduler.sv
// Two-runway scheduler: class-priority round-robin arbitration over N_REQ requesters.
module runway_scheduler
    import runway_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int OCC_CYCLES   = OCC_CYCLES_DEF,
    parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] land,
    input  logic [N_REQ-1:0] emerg,
    input  logic [1:0]       rwy_close,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_rwy,
    output logic [3:0]       rwy_state
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] r_gnt;
    logic             r_gnt_rwy;
    logic [IDX_W-1:0] r_ptr;

    logic [1:0]       w_state_a;
    logic [1:0]       w_state_b;
    logic             w_avail_a;
    logic             w_avail_b;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_cls_emerg;
    logic [N_REQ-1:0] w_cls_land;
    logic [N_REQ-1:0] w_cls_take;
    logic [N_REQ-1:0] w_cls_sel;
    logic             w_pick_found;
    logic [IDX_W-1:0] w_pick_idx;
    logic [N_REQ-1:0] w_gnt_vec;
    logic             w_do_grant;
    logic             w_grant_a;
    logic             w_grant_b;

    assign w_avail_a = (w_state_a == RWY_FREE) && !rwy_close[0];
    assign w_avail_b = (w_state_b == RWY_FREE) && !rwy_close[1];

    // A requester still showing its grant pulse is not re-considered this cycle.
    assign w_elig      = req & ~r_gnt;
    assign w_cls_emerg = w_elig & emerg;
    assign w_cls_land  = w_elig & ~emerg & land;
    assign w_cls_take  = w_elig & ~emerg & ~land;

    always_comb begin
        w_cls_sel = w_cls_take;
        if (|w_cls_emerg)
            w_cls_sel = w_cls_emerg;
        else if (|w_cls_land)
            w_cls_sel = w_cls_land;
    end

    always_comb begin : rr_pick
        logic [IDX_W:0] cand;
        cand         = '0;
        w_pick_found = 1'b0;
        w_pick_idx   = r_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!w_pick_found && w_cls_sel[cand[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_vec             = '0;
        w_gnt_vec[w_pick_idx] = 1'b1;
    end

    assign w_do_grant = (w_avail_a || w_avail_b) && w_pick_found;
    assign w_grant_a  = w_do_grant && w_avail_a;
    assign w_grant_b  = w_do_grant && !w_avail_a && w_avail_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_gnt_rwy <= 1'b0;
            r_ptr     <= IDX_W'(N_REQ - 1);
        end else begin
            r_gnt     <= w_do_grant ? w_gnt_vec : '0;
            r_gnt_rwy <= w_grant_b;
            if (w_do_grant)
                r_ptr <= w_pick_idx;
        end
    end

    runway_slot #(
        .OCC_CYCLES  (OCC_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) u_slot_a (
        .clk    (clk),
        .rst    (rst),
        .i_grant(w_grant_a),
        .i_close(rwy_close[0]),
        .o_state(w_state_a)
    );

    runway_slot #(
        .OCC_CYCLES  (OCC_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) u_slot_b (
        .clk    (clk),
        .rst    (rst),
        .i_grant(w_grant_b),
        .i_close(rwy_close[1]),
        .o_state(w_state_b)
    );

    assign gnt       = r_gnt;
    assign gnt_rwy   = r_gnt_rwy;
    assign rwy_state = {w_state_b, w_state_a};

endmodule

// File: tb/tb_runway_scheduler.sv
// Directed bench for runway_scheduler with hand-computed grant order and runway timing.
module tb_runway_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] land;
    logic [3:0] emerg;
    logic [1:0] rwy_close;
    logic [3:0] gnt;
    logic       gnt_rwy;
    logic [3:0] rwy_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    runway_scheduler #(
        .N_REQ       (4),
        .OCC_CYCLES  (12),
        .CLEAR_CYCLES(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .land     (land),
        .emerg    (emerg),
        .rwy_close(rwy_close),
        .gnt      (gnt),
        .gnt_rwy  (gnt_rwy),
        .rwy_state(rwy_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until the next grant pulse, capped at budget.
    task automatic wait_gnt(input int budget, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while ((gnt == 4'b0000) && (cycles < budget));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; land = '0; emerg = '0; rwy_close = '0;
        tick();
        check("rst_state", 32'(rwy_state), 'h0);
        check("rst_gnt",   32'(gnt),       'h0);
        check("rst_rwy",   32'(gnt_rwy),   'h0);

        // Single landing: one-cycle latency, 12 occupied, 3 clearing.
        rst = 1'b0; req = 4'b0001; land = 4'b0001;
        tick();
        check("s1_gnt", 32'(gnt),       'h1);
        check("s1_rwy", 32'(gnt_rwy),   'h0);
        check("s1_occ", 32'(rwy_state), 'h1);
        req = '0; land = '0;
        tick();
        check("s1_pulse", 32'(gnt), 'h0);
        tick(10);
        check("s1_occ_last", 32'(rwy_state), 'h1);
        tick();
        check("s1_clr_first", 32'(rwy_state), 'h2);
        tick(2);
        check("s1_clr_last", 32'(rwy_state), 'h2);
        tick();
        check("s1_free", 32'(rwy_state), 'h0);

        // Two takeoffs: A then B on consecutive edges, then nothing.
        req = 4'b0110;
        tick();
        check("s2_g1",     32'(gnt),       'h2);
        check("s2_g1_rwy", 32'(gnt_rwy),   'h0);
        check("s2_g1_st",  32'(rwy_state), 'h1);
        tick();
        check("s2_g2",     32'(gnt),       'h4);
        check("s2_g2_rwy", 32'(gnt_rwy),   'h1);
        check("s2_g2_st",  32'(rwy_state), 'h5);
        tick();
        check("s2_none", 32'(gnt), 'h0);
        tick(5);
        check("s2_none_late", 32'(gnt), 'h0);
        req = '0;
        tick(20);
        check("s2_idle", 32'(rwy_state), 'h0);

        // B closed, A only: emergency, landing, then takeoffs round-robin.
        req = 4'b1111; emerg = 4'b1000; land = 4'b0100; rwy_close = 2'b10;
        tick();
        check("s3_g3",    32'(gnt),       'h8);
        check("s3_g3_rw", 32'(gnt_rwy),   'h0);
        check("s3_st",    32'(rwy_state), 'hD);
        req = 4'b0111;
        wait_gnt(40, cyc);
        check("s3_lat2", 32'(cyc), 'd16);
        check("s3_g2",   32'(gnt), 'h4);
        check("s3_g2_rw", 32'(gnt_rwy), 'h0);
        req = 4'b0011;
        wait_gnt(40, cyc);
        check("s3_lat0", 32'(cyc), 'd16);
        check("s3_g0",   32'(gnt), 'h1);
        req = 4'b0010;
        wait_gnt(40, cyc);
        check("s3_lat1", 32'(cyc), 'd16);
        check("s3_g1",   32'(gnt), 'h2);
        req = '0; emerg = '0; land = '0; rwy_close = 2'b00;
        tick();
        check("s3_b_reopen", 32'(rwy_state), 'h1);
        tick(20);
        check("s3_idle", 32'(rwy_state), 'h0);

        // Close A while occupied: full sequence, then CLOSED; grants go to B.
        req = 4'b1001;
        tick();
        check("s4_rr", 32'(gnt),       'h8);
        check("s4_st", 32'(rwy_state), 'h1);
        req = '0; rwy_close = 2'b01;
        tick(14);
        check("s4_clearing", 32'(rwy_state), 'h2);
        tick();
        check("s4_closed", 32'(rwy_state), 'h3);
        req = 4'b0010;
        tick();
        check("s4_gb",    32'(gnt),       'h2);
        check("s4_gb_rw", 32'(gnt_rwy),   'h1);
        check("s4_gb_st", 32'(rwy_state), 'h7);
        req = 4'b0100;
        wait_gnt(40, cyc);
        check("s4_lat",    32'(cyc),       'd16);
        check("s4_gb2",    32'(gnt),       'h4);
        check("s4_gb2_rw", 32'(gnt_rwy),   'h1);
        check("s4_gb2_st", 32'(rwy_state), 'h7);
        req = '0; rwy_close = 2'b00;
        tick();
        check("s4_reopen", 32'(rwy_state), 'h4);

        // Reset mid-occupancy with requests held.
        tick(20);
        check("s5_idle", 32'(rwy_state), 'h0);
        req = 4'b0011;
        tick();
        check("s5_ga", 32'(gnt), 'h1);
        tick();
        check("s5_gb",    32'(gnt),       'h2);
        check("s5_gb_st", 32'(rwy_state), 'h5);
        tick(3);
        check("s5_busy", 32'(gnt), 'h0);
        rst = 1'b1;
        tick();
        check("s5_rst_st",  32'(rwy_state), 'h0);
        check("s5_rst_gnt", 32'(gnt),       'h0);
        check("s5_rst_rwy", 32'(gnt_rwy),   'h0);
        rst = 1'b0;
        tick();
        check("s5_post",    32'(gnt),       'h1);
        check("s5_post_rw", 32'(gnt_rwy),   'h0);
        check("s5_post_st", 32'(rwy_state), 'h1);
        tick();
        check("s5_post2", 32'(gnt), 'h2);
        req = '0;
        tick(20);
        check("s5_idle2", 32'(rwy_state), 'h0);

        // Close and grant aimed at A on the same edge: close wins, grant lands on B.
        req = 4'b0100; rwy_close = 2'b01;
        tick();
        check("s6_gnt", 32'(gnt),       'h4);
        check("s6_rw",  32'(gnt_rwy),   'h1);
        check("s6_st",  32'(rwy_state), 'h7);
        req = '0; rwy_close = 2'b00;
        tick(20);
        check("s6_idle", 32'(rwy_state), 'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/runway_scheduler.md
RUNWAY_SCHEDULER -- requirements
Module: runway_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of aircraft requesters.
REQ-002 Parameter OCC_CYCLES, default 12: cycles a granted runway stays OCCUPIED.
REQ-003 Parameter CLEAR_CYCLES, default 3: post-occupancy clearance cycles.
REQ-004 One clock; reset is synchronous and active-high. Port clk, input, 1: the single clock.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port req, input, N_REQ: per-requester runway request, held high until granted.
REQ-007 Port land, input, N_REQ: request type; 1 = landing, 0 = takeoff; valid while req is high.
REQ-008 Port emerg, input, N_REQ: emergency flag; valid while req is high.
REQ-009 Port rwy_close, input, 2: close request; bit0 = runway A, bit1 = runway B.
REQ-010 Port gnt, output, N_REQ: registered one-hot grant pulse, one cycle wide.
REQ-011 Port gnt_rwy, output, 1: runway of the current grant; 0 = A, 1 = B; meaningful only while gnt is non-zero.
REQ-012 Port rwy_state, output, 4: [1:0] = A, [3:2] = B; encoding 00 FREE, 01 OCCUPIED, 10 CLEARING, 11 CLOSED.

Function
REQ-013 Each runway has its own FSM:
- FREE -> OCCUPIED on a grant to that runway.
- OCCUPIED -> CLEARING after exactly OCC_CYCLES cycles in OCCUPIED.
- CLEARING -> FREE after exactly CLEAR_CYCLES cycles in CLEARING.
REQ-014 FREE -> CLOSED when its rwy_close bit is high. CLOSED -> FREE on the first edge at which the bit is low.
REQ-015 rwy_close seen in OCCUPIED or CLEARING does not abort the sequence; the runway enters CLOSED on the edge at which it would otherwise enter FREE, if the bit is still high.
REQ-016 Grant conditions: a grant is issued at an edge only if some runway is FREE, its close bit is low, and at least one eligible req is high. At most one grant per edge.
REQ-017 Eligibility: a requester whose gnt bit is currently high is masked; its req is ignored that cycle.
REQ-018 Runway selection: A if eligible, else B.
REQ-019 Requester priority, by class: emergency first, then landing, then takeoff.
- Within a class: round-robin starting at the index after the last granted index.
- The pointer updates only on a grant.
REQ-020 Timing: gnt, gnt_rwy and the runway's FREE -> OCCUPIED transition update on the same edge. Latency from a req sampled high to gnt is one cycle when a runway is available.
REQ-021 Simultaneous events: two requests with both runways FREE give one grant on A at edge n and the other on B at edge n+1.
REQ-022 Close/grant conflict: close and grant targeting the same runway at the same edge resolve to close; the grant goes to the other runway if it is eligible, otherwise none.
REQ-023 Counters are sized clog2(max(OCC_CYCLES, CLEAR_CYCLES)+1), reset to 0 on every state entry, and never wrap.

Reset
REQ-024 With rst high at an edge:
- Both runways FREE, counters 0, gnt 0, gnt_rwy 0.
- Round-robin pointer = N_REQ-1, so index 0 is favoured first.
REQ-025 Reset mid-operation aborts occupancy and drops any grant in flight; outputs show the reset values the cycle after the edge.

Structure
REQ-026 Shared package runway_pkg holds the runway state typedef/encoding and the default OCC_CYCLES and CLEAR_CYCLES constants.
REQ-027 Sub-module runway_slot implements one runway FSM plus counter and is instantiated twice. Arbitration logic lives in runway_scheduler.

Verification
REQ-028 Reset, then req=0001, land=0001: gnt=0001 and gnt_rwy=0 one cycle later; A OCCUPIED 12 cycles, CLEARING 3, then FREE.
REQ-029 req=0110 held, both runways FREE: gnt=0010 on A, next cycle gnt=0100 on B; no third grant while both runways are busy.
REQ-030 req=1111, emerg=1000, land=0100, one runway free: grant order across successive frees is 3, 2, then 0 and 1 by round-robin.
REQ-031 rwy_close=01 during A OCCUPIED: A completes 12+3 cycles, enters CLOSED, and all grants go to B until rwy_close=00.
REQ-032 rst pulsed mid-OCCUPIED with req=0011 held: next cycle rwy_state=0000 and gnt=0000; the first post-reset grant goes to index 0.
